// File: rtl/icb_rr_arbiter.sv
// rtl/icb_rr_arbiter.sv - N:1 ICB command arbiter with burst lock and in-order response routing
//
// Shares one downstream ICB master port between N upstream requesters.
// A grant is given per burst and held until every beat of the burst has been
// accepted. Each accepted beat records the requester index in an outstanding
// ID FIFO. Responses return one per beat, in order, and are steered to the
// requester at the FIFO head.
//
// Optional feature: define ICB_ARB_FIXED_PRIO_EN for fixed lowest-index-first
// priority. When it is undefined, arbitration is round-robin.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   s_cmd_*           per-requester command channels, requester i at slice i
//   s_rsp_valid/ready per-requester response handshake
//   s_rsp_rdata/err   shared response payload, qualified by s_rsp_valid[i]
//   m_cmd_*           downstream command channel
//   m_rsp_*           downstream response channel
module icb_rr_arbiter #(
    parameter int N          = 2,
    parameter int ADDR_W     = 32,
    parameter int WIDTH      = 32,
    parameter int ICB_LEN_W  = 3,
    parameter int OUTS_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N-1:0]               s_cmd_valid,
    output logic [N-1:0]               s_cmd_ready,
    input  logic [N*ADDR_W-1:0]        s_cmd_addr,
    input  logic [N-1:0]               s_cmd_read,
    input  logic [N*ICB_LEN_W-1:0]     s_cmd_len,
    input  logic [N*WIDTH-1:0]         s_cmd_wdata,
    input  logic [N*(WIDTH/8)-1:0]     s_cmd_wmask,
    output logic [N-1:0]               s_rsp_valid,
    input  logic [N-1:0]               s_rsp_ready,
    output logic [WIDTH-1:0]           s_rsp_rdata,
    output logic                       s_rsp_err,
    output logic                       m_cmd_valid,
    input  logic                       m_cmd_ready,
    output logic [ADDR_W-1:0]          m_cmd_addr,
    output logic                       m_cmd_read,
    output logic [ICB_LEN_W-1:0]       m_cmd_len,
    output logic [WIDTH-1:0]           m_cmd_wdata,
    output logic [(WIDTH/8)-1:0]       m_cmd_wmask,
    input  logic                       m_rsp_valid,
    output logic                       m_rsp_ready,
    input  logic [WIDTH-1:0]           m_rsp_rdata,
    input  logic                       m_rsp_err
);

    localparam int DW    = WIDTH / 8;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int PTR_W = $clog2(OUTS_DEPTH);

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [IDX_W-1:0]       gnt_idx;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_found;
    logic [IDX_W-1:0]       scan_base;
    logic [IDX_W:0]         scan;
    logic [ICB_LEN_W-1:0]   beat_cnt;
    logic [ICB_LEN_W-1:0]   len_lat;
    logic                   beat_fire;
    logic                   last_beat;

    logic [IDX_W-1:0]       id_mem [OUTS_DEPTH];
    logic [PTR_W:0]         wr_ptr;
    logic [PTR_W:0]         rd_ptr;
    logic                   id_full;
    logic                   id_empty;
    logic                   push;
    logic                   pop;
    logic [IDX_W-1:0]       head;

    // ------------------------------------------------------------------
    // Arbitration: scan N candidates starting at scan_base, wrapping at N.
    // ------------------------------------------------------------------
`ifdef ICB_ARB_FIXED_PRIO_EN
    assign scan_base = '0;
`else
    logic [IDX_W-1:0] rr_ptr;

    assign scan_base = rr_ptr;

    // The requester after the one that just finished gets first look next time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (beat_fire && last_beat) begin
            rr_ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`endif

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = '0;
        for (int k = 0; k < N; k++) begin
            scan = {1'b0, scan_base} + (IDX_W + 1)'(k);
            if (scan >= (IDX_W + 1)'(N)) begin
                scan = scan - (IDX_W + 1)'(N);
            end
            if (!pick_found && s_cmd_valid[scan[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan[IDX_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (pick_found) state_nxt = BURST;
            BURST:   if (beat_fire && last_beat) state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_idx  <= '0;
            len_lat  <= '0;
            beat_cnt <= '0;
        end else if (state == ARB) begin
            beat_cnt <= '0;
            if (pick_found) begin
                gnt_idx <= pick_idx;
                len_lat <= s_cmd_len[int'(pick_idx)*ICB_LEN_W +: ICB_LEN_W];
            end
        end else if (beat_fire) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Command path: the granted slice is forwarded; acceptance stalls while
    // the ID FIFO cannot record another beat.
    // ------------------------------------------------------------------
    assign m_cmd_addr  = s_cmd_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign m_cmd_read  = s_cmd_read[gnt_idx];
    assign m_cmd_len   = s_cmd_len[int'(gnt_idx)*ICB_LEN_W +: ICB_LEN_W];
    assign m_cmd_wdata = s_cmd_wdata[int'(gnt_idx)*WIDTH +: WIDTH];
    assign m_cmd_wmask = s_cmd_wmask[int'(gnt_idx)*DW +: DW];
    assign m_cmd_valid = (state == BURST) && s_cmd_valid[gnt_idx] && !id_full;
    assign beat_fire   = m_cmd_valid && m_cmd_ready;
    assign last_beat   = (beat_cnt == len_lat);

    always_comb begin
        s_cmd_ready = '0;
        if (state == BURST) begin
            s_cmd_ready[gnt_idx] = m_cmd_ready && !id_full;
        end
    end

    // ------------------------------------------------------------------
    // Outstanding ID FIFO: pointers carry one extra wrap bit.
    // ------------------------------------------------------------------
    assign push     = beat_fire;
    assign pop      = m_rsp_valid && m_rsp_ready;
    assign id_empty = (wr_ptr == rd_ptr);
    assign id_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head     = id_mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr[PTR_W-1:0]] <= gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Response path: zero-latency steer to the head requester. A response
    // arriving with nothing outstanding is left waiting (ready stays low).
    // ------------------------------------------------------------------
    assign m_rsp_ready = !id_empty && s_rsp_ready[head];
    assign s_rsp_rdata = m_rsp_rdata;
    assign s_rsp_err   = m_rsp_err;

    always_comb begin
        s_rsp_valid = '0;
        if (!id_empty) begin
            s_rsp_valid[head] = m_rsp_valid;
        end
    end

endmodule

// File: tb/tb_icb_rr_arbiter.sv
// tb/tb_icb_rr_arbiter.sv - directed self-checking bench for icb_rr_arbiter
module tb_icb_rr_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int W  = 32;
    localparam int LW = 3;
    localparam int OD = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      s_cmd_valid;
    logic [N-1:0]      s_cmd_ready;
    logic [N*AW-1:0]   s_cmd_addr;
    logic [N-1:0]      s_cmd_read;
    logic [N*LW-1:0]   s_cmd_len;
    logic [N*W-1:0]    s_cmd_wdata;
    logic [N*W/8-1:0]  s_cmd_wmask;
    logic [N-1:0]      s_rsp_valid;
    logic [N-1:0]      s_rsp_ready;
    logic [W-1:0]      s_rsp_rdata;
    logic              s_rsp_err;
    logic              m_cmd_valid;
    logic              m_cmd_ready;
    logic [AW-1:0]     m_cmd_addr;
    logic              m_cmd_read;
    logic [LW-1:0]     m_cmd_len;
    logic [W-1:0]      m_cmd_wdata;
    logic [W/8-1:0]    m_cmd_wmask;
    logic              m_rsp_valid;
    logic              m_rsp_ready;
    logic [W-1:0]      m_rsp_rdata;
    logic              m_rsp_err;

    int checks   = 0;
    int failures = 0;
    int fires;

    icb_rr_arbiter #(
        .N(N), .ADDR_W(AW), .WIDTH(W), .ICB_LEN_W(LW), .OUTS_DEPTH(OD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
        .s_cmd_addr(s_cmd_addr), .s_cmd_read(s_cmd_read),
        .s_cmd_len(s_cmd_len), .s_cmd_wdata(s_cmd_wdata),
        .s_cmd_wmask(s_cmd_wmask),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
        .s_rsp_rdata(s_rsp_rdata), .s_rsp_err(s_rsp_err),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .m_cmd_addr(m_cmd_addr), .m_cmd_read(m_cmd_read),
        .m_cmd_len(m_cmd_len), .m_cmd_wdata(m_cmd_wdata),
        .m_cmd_wmask(m_cmd_wmask),
        .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
        .m_rsp_rdata(m_rsp_rdata), .m_rsp_err(m_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        s_cmd_valid = '0;
        s_cmd_addr  = '0;
        s_cmd_read  = '0;
        s_cmd_len   = '0;
        s_cmd_wdata = '0;
        s_cmd_wmask = '0;
        s_rsp_ready = '0;
        m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b0;
        m_rsp_rdata = '0;
        m_rsp_err   = 1'b0;
        repeat (2) tick();

        // Reset state, with live inputs trying to provoke every output.
        s_cmd_valid = 2'b11; m_cmd_ready = 1'b1; m_rsp_valid = 1'b1; s_rsp_ready = 2'b11;
        #1;
        check("rst_m_cmd_valid", m_cmd_valid, 0);
        check("rst_s_cmd_ready", s_cmd_ready, 0);
        check("rst_s_rsp_valid", s_rsp_valid, 0);
        check("rst_m_rsp_ready", m_rsp_ready, 0);
        s_cmd_valid = '0; m_cmd_ready = 1'b0; m_rsp_valid = 1'b0; s_rsp_ready = '0;
        rst_n = 1'b1;
        tick();

        // Single requester 1, write, len=2.
        s_cmd_valid = 2'b10; s_cmd_read = 2'b00; s_cmd_len[5:3] = 3'd2;
        s_cmd_addr[63:32] = 32'h1000; s_cmd_wdata[63:32] = 32'hDEAD0000;
        s_cmd_wmask[7:4] = 4'hC; m_cmd_ready = 1'b1;
        #1 check("t1_bubble", m_cmd_valid, 0);
        tick();
        for (int b = 0; b < 3; b++) begin
            s_cmd_addr[63:32]  = 32'h1000 + 32'(4 * b);
            s_cmd_wdata[63:32] = 32'hDEAD0000 + 32'(b);
            #1;
            check("t1_valid", m_cmd_valid, 1);
            check("t1_addr", m_cmd_addr, 64'h1000 + 64'(4 * b));
            check("t1_wdata", m_cmd_wdata, 64'hDEAD0000 + 64'(b));
            check("t1_wmask", m_cmd_wmask, 4'hC);
            check("t1_len", m_cmd_len, 2);
            check("t1_read", m_cmd_read, 0);
            check("t1_ready", s_cmd_ready, 2'b10);
            tick();
        end
        s_cmd_valid = '0; m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b1; s_rsp_ready = 2'b10;
        for (int r = 0; r < 3; r++) begin
            m_rsp_rdata = 32'hA000 + 32'(r);
            m_rsp_err   = (r == 1);
            #1;
            check("t1_rsp_valid", s_rsp_valid, 2'b10);
            check("t1_rsp_ready", m_rsp_ready, 1);
            check("t1_rsp_rdata", s_rsp_rdata, 64'hA000 + 64'(r));
            check("t1_rsp_err", s_rsp_err, (r == 1) ? 1 : 0);
            tick();
        end
        #1;
        check("t1_empty_valid", s_rsp_valid, 0);
        check("t1_empty_ready", m_rsp_ready, 0);
        m_rsp_valid = 1'b0; s_rsp_ready = '0; m_rsp_err = 1'b0;

        // Round-robin fairness: both valid, len=0; pointer must be back at 0.
        s_cmd_valid = 2'b11; s_cmd_len = '0; s_cmd_read = 2'b11;
        s_cmd_addr = {32'h000000B0, 32'h000000A0}; m_cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("t2_bubble", m_cmd_valid, 0);
            tick();
            #1;
            check("t2_valid", m_cmd_valid, 1);
            check("t2_grant", s_cmd_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
            check("t2_addr", m_cmd_addr, (i % 2 == 1) ? 32'hB0 : 32'hA0);
            check("t2_read", m_cmd_read, 1);
            tick();
        end
        s_cmd_valid = '0; m_cmd_ready = 1'b0;

        // Response backpressure: outstanding 0,1,0,1 with requester 0 not ready.
        m_rsp_valid = 1'b1; s_rsp_ready = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t5_hold_ready", m_rsp_ready, 0);
            check("t5_hold_valid", s_rsp_valid, 2'b01);
            tick();
        end
        s_rsp_ready = 2'b11;
        for (int r = 0; r < 4; r++) begin
            #1;
            check("t5_route", s_rsp_valid, (r % 2 == 1) ? 2'b10 : 2'b01);
            check("t5_ready", m_rsp_ready, 1);
            tick();
        end
        m_rsp_valid = 1'b0; s_rsp_ready = '0;

        // Burst lock: requester 0 len=3, requester 1 joins at beat 1.
        s_cmd_valid = 2'b01; s_cmd_len[2:0] = 3'd3; s_cmd_len[5:3] = 3'd0;
        s_cmd_read = 2'b00; m_cmd_ready = 1'b1;
        #1 check("t3_bubble0", m_cmd_valid, 0);
        tick();
        for (int b = 0; b < 4; b++) begin
            if (b == 1) s_cmd_valid = 2'b11;
            #1;
            check("t3_lock", s_cmd_ready, 2'b01);
            check("t3_addr", m_cmd_addr, 32'hA0);
            tick();
        end
        #1 check("t3_bubble1", m_cmd_valid, 0);
        tick();
        #1 check("t3_next", s_cmd_ready, 2'b10);
        tick();
        s_cmd_valid = '0; m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b1; s_rsp_ready = 2'b11;
        for (int r = 0; r < 5; r++) begin
            #1 check("t3_rsp_order", s_rsp_valid, (r == 4) ? 2'b10 : 2'b01);
            tick();
        end
        m_rsp_valid = 1'b0; s_rsp_ready = '0;

        // Outstanding full: requester 0 len=3 repeatedly, no responses.
        s_cmd_valid = 2'b01; s_cmd_len[2:0] = 3'd3; m_cmd_ready = 1'b1;
        fires = 0;
        for (int c = 0; c < 14; c++) begin
            #1 if (m_cmd_valid && m_cmd_ready) fires++;
            tick();
        end
        check("t4_fires_to_full", fires, 8);
        #1;
        check("t4_stall_valid", m_cmd_valid, 0);
        check("t4_stall_ready", s_cmd_ready, 0);
        m_rsp_valid = 1'b1; s_rsp_ready = 2'b01;
        #1;
        check("t4_pop_ready", m_rsp_ready, 1);
        check("t4_no_push_full", m_cmd_valid, 0);
        tick();
        m_rsp_valid = 1'b0;
        fires = 0;
        for (int c = 0; c < 5; c++) begin
            #1 if (m_cmd_valid && m_cmd_ready) fires++;
            tick();
        end
        check("t4_one_more", fires, 1);
        #1 check("t4_refull", m_cmd_valid, 0);

        // Reset mid-burst: drain, advance to beat 2 of the len=3 burst, reset.
        m_cmd_ready = 1'b0; m_rsp_valid = 1'b1; s_rsp_ready = 2'b01;
        for (int r = 0; r < 8; r++) begin
            #1 check("t6_drain", s_rsp_valid, 2'b01);
            tick();
        end
        m_rsp_valid = 1'b0; s_rsp_ready = '0; m_cmd_ready = 1'b1;
        #1 check("t6_beat1", m_cmd_valid, 1);
        tick();
        #1 check("t6_beat2", m_cmd_valid, 1);
        rst_n = 1'b0; s_cmd_valid = 2'b11; m_rsp_valid = 1'b1; s_rsp_ready = 2'b11;
        tick();
        rst_n = 1'b1;
        #1;
        check("t6_m_cmd_valid", m_cmd_valid, 0);
        check("t6_s_cmd_ready", s_cmd_ready, 0);
        check("t6_s_rsp_valid", s_rsp_valid, 0);
        check("t6_m_rsp_ready", m_rsp_ready, 0);
        tick();
        #1 check("t6_rr_reset", s_cmd_ready, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
